// File: rtl/audio_stream_ctrl.sv
// audio_stream_ctrl: Avalon-MM master that clears the audio core's write FIFO,
// then repeatedly polls FIFOSPACE and streams left/right sample pairs from a
// valid/ready source into the LEFTDATA/RIGHTDATA registers.
module audio_stream_ctrl #(
  parameter int POLL_GAP = 15,
  parameter int RD_LAT   = 1
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic        enable,
  input  logic [31:0] smp_left,
  input  logic [31:0] smp_right,
  input  logic        smp_valid,
  output logic        smp_ready,
  output logic [1:0]  avm_address,
  output logic        avm_chipselect,
  output logic        avm_read,
  output logic        avm_write,
  output logic [31:0] avm_writedata,
  input  logic [31:0] avm_readdata,
  output logic [7:0]  space_obs,
  output logic [15:0] pairs_sent,
  output logic        busy
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_CLR,
    S_CLR_REL,
    S_POLL,
    S_WAIT_RD,
    S_WAIT_SMP,
    S_WR_L,
    S_WR_R,
    S_GAP
  } state_t;

  localparam logic [1:0]  A_CONTROL   = 2'd0;
  localparam logic [1:0]  A_FIFOSPACE = 2'd1;
  localparam logic [1:0]  A_LEFTDATA  = 2'd2;
  localparam logic [1:0]  A_RIGHTDATA = 2'd3;
  localparam logic [31:0] CTRL_CLEAR  = 32'h0000_0008;
  localparam logic [15:0] RD_LAST     = 16'(RD_LAT - 1);
  localparam logic [15:0] GAP_LAST    = 16'(POLL_GAP - 1);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  space_q, space_d;
  logic [7:0]  space_obs_q, space_obs_d;
  logic [15:0] pairs_q, pairs_d;
  logic        ready_q, ready_d;
  logic        rd_q, rd_d;
  logic        wr_q, wr_d;
  logic        cs_q, cs_d;
  logic [1:0]  addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        busy_q, busy_d;
  logic [31:0] right_q, right_d;
  logic [7:0]  rd_space;

  function automatic logic [7:0] min8(input logic [7:0] a, input logic [7:0] b);
    return (a < b) ? a : b;
  endfunction

  // Usable pair count is limited by the fuller of the two write FIFOs.
  assign rd_space = min8(avm_readdata[31:24], avm_readdata[23:16]);

  // Next-state logic; bus outputs are decoded from the next state so every
  // strobe is registered and lines up with the state that issues it.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    space_d     = space_q;
    space_obs_d = space_obs_q;
    pairs_d     = pairs_q;
    right_d     = right_q;
    wdata_d     = 32'd0;
    addr_d      = 2'd0;
    rd_d        = 1'b0;
    wr_d        = 1'b0;

    case (state_q)
      S_IDLE:    if (enable) state_d = S_CLR;
      S_CLR:     state_d = S_CLR_REL;
      S_CLR_REL: state_d = S_POLL;
      S_POLL: begin
        state_d = S_WAIT_RD;
        cnt_d   = 16'd0;
      end
      S_WAIT_RD: begin
        if (cnt_q == RD_LAST) begin
          space_d     = rd_space;
          space_obs_d = rd_space;
          if ((rd_space != 8'd0) && enable) begin
            state_d = S_WAIT_SMP;
          end else if (!enable) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_GAP;
            cnt_d   = 16'd0;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_WAIT_SMP: begin
        // A handshake wins over a simultaneous enable drop: the pair completes.
        if (smp_valid) begin
          right_d = smp_right;
          wdata_d = smp_left;
          state_d = S_WR_L;
        end else if (!enable) begin
          state_d = S_IDLE;
        end
      end
      S_WR_L: begin
        state_d = S_WR_R;
        space_d = space_q - 8'd1;
        pairs_d = pairs_q + 16'd1;
      end
      S_WR_R: begin
        if (!enable) begin
          state_d = S_IDLE;
        end else if (space_q != 8'd0) begin
          state_d = S_WAIT_SMP;
        end else begin
          state_d = S_GAP;
          cnt_d   = 16'd0;
        end
      end
      S_GAP: begin
        if (!enable) begin
          state_d = S_IDLE;
        end else if (cnt_q == GAP_LAST) begin
          state_d = S_POLL;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    case (state_d)
      S_CLR: begin
        wr_d    = 1'b1;
        addr_d  = A_CONTROL;
        wdata_d = CTRL_CLEAR;
      end
      S_CLR_REL: begin
        wr_d    = 1'b1;
        addr_d  = A_CONTROL;
        wdata_d = 32'd0;
      end
      S_POLL: begin
        rd_d    = 1'b1;
        addr_d  = A_FIFOSPACE;
        wdata_d = 32'd0;
      end
      S_WR_L: begin
        wr_d   = 1'b1;
        addr_d = A_LEFTDATA;
      end
      S_WR_R: begin
        wr_d    = 1'b1;
        addr_d  = A_RIGHTDATA;
        wdata_d = right_q;
      end
      default: wdata_d = 32'd0;
    endcase

    cs_d    = rd_d | wr_d;
    ready_d = (state_d == S_WAIT_SMP);
    busy_d  = (state_d != S_IDLE);
  end

  // Control state and registered bus outputs; reset drops strobes at once.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= 16'd0;
      space_q     <= 8'd0;
      space_obs_q <= 8'd0;
      pairs_q     <= 16'd0;
      ready_q     <= 1'b0;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      cs_q        <= 1'b0;
      addr_q      <= 2'd0;
      wdata_q     <= 32'd0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      space_q     <= space_d;
      space_obs_q <= space_obs_d;
      pairs_q     <= pairs_d;
      ready_q     <= ready_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      cs_q        <= cs_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      busy_q      <= busy_d;
    end
  end

  // Right-sample holding register; pure data, so it carries no reset.
  always_ff @(posedge clk_clk) begin
    right_q <= right_d;
  end

  assign smp_ready      = ready_q;
  assign avm_address    = addr_q;
  assign avm_chipselect = cs_q;
  assign avm_read       = rd_q;
  assign avm_write      = wr_q;
  assign avm_writedata  = wdata_q;
  assign space_obs      = space_obs_q;
  assign pairs_sent     = pairs_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_audio_stream_ctrl.sv
// Directed bench for audio_stream_ctrl with a FIFOSPACE slave responder and a
// write scoreboard fed by observed sample handshakes.
module tb_audio_stream_ctrl;
  localparam int POLL_GAP    = 4;
  localparam int RD_LAT      = 2;
  localparam int POLL_PERIOD = 1 + RD_LAT + POLL_GAP;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [31:0] smp_left;
  logic [31:0] smp_right;
  logic        smp_valid;
  logic        smp_ready;
  logic [1:0]  avm_address;
  logic        avm_chipselect;
  logic        avm_read;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic [31:0] readdata;
  logic [7:0]  space_obs;
  logic [15:0] pairs_sent;
  logic        busy;

  int          n_pass  = 0;
  int          n_total = 0;
  int          cyc     = 0;
  int          last_wrr = 0;
  int          ready_cnt = 0;
  logic [33:0] sb[$];
  int          rd_cyc[$];
  int          hs_cyc[$];
  logic [31:0] fifospace;
  logic [7:0]  rd_hist;

  audio_stream_ctrl #(.POLL_GAP(POLL_GAP), .RD_LAT(RD_LAT)) dut (
    .clk_clk        (clk),
    .reset_reset_n  (rst_n),
    .enable         (enable),
    .smp_left       (smp_left),
    .smp_right      (smp_right),
    .smp_valid      (smp_valid),
    .smp_ready      (smp_ready),
    .avm_address    (avm_address),
    .avm_chipselect (avm_chipselect),
    .avm_read       (avm_read),
    .avm_write      (avm_write),
    .avm_writedata  (avm_writedata),
    .avm_readdata   (readdata),
    .space_obs      (space_obs),
    .pairs_sent     (pairs_sent),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Sample source: fresh random pair every cycle, away from the clock edge.
  initial begin
    smp_left  = $urandom;
    smp_right = $urandom;
    forever begin
      @(posedge clk);
      #2;
      smp_left  = $urandom;
      smp_right = $urandom;
    end
  end

  // Slave responder and bus monitor, sampling on the falling edge.
  initial begin
    logic [33:0] exp_w;
    rd_hist  = 8'd0;
    readdata = $urandom;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        rd_hist = 8'd0;
      end else begin
        rd_hist  = {rd_hist[6:0], avm_read};
        readdata = rd_hist[RD_LAT] ? fifospace : 32'h0000_FFFF;
        chk("bus_rule",
            64'({avm_chipselect, avm_read & avm_write,
                 (avm_read | avm_write) ? 34'd0 : {avm_address, avm_writedata}}),
            64'({avm_read | avm_write, 1'b0, 34'd0}));
        if (smp_ready) ready_cnt++;
        if (avm_read) begin
          chk("rd_addr_data", 64'({avm_address, avm_writedata}), 64'({2'd1, 32'd0}));
          rd_cyc.push_back(cyc);
        end
        if (avm_write) begin
          chk("wr_expected", 64'(sb.size() != 0), 64'd1);
          if (sb.size() != 0) begin
            exp_w = sb.pop_front();
            chk("wr_addr_data", 64'({avm_address, avm_writedata}), 64'(exp_w));
          end
          if (avm_address == 2'd3) last_wrr = cyc;
        end
        if (smp_valid && smp_ready) begin
          sb.push_back({2'd2, smp_left});
          sb.push_back({2'd3, smp_right});
          hs_cyc.push_back(cyc);
        end
      end
    end
  end

  initial begin
    int t0;
    int base_hs;
    int base_rdy;

    // Reset with random control inputs
    rst_n     = 1'b0;
    enable    = 1'($urandom_range(0, 1));
    smp_valid = 1'($urandom_range(0, 1));
    fifospace = 32'd0;
    repeat (3) @(negedge clk);
    chk("rst_strobes", 64'({avm_read, avm_write, avm_chipselect}), 64'd0);
    chk("rst_addr_data", 64'({avm_address, avm_writedata}), 64'd0);
    chk("rst_ready_busy", 64'({smp_ready, busy}), 64'd0);
    chk("rst_space_obs", 64'(space_obs), 64'd0);
    chk("rst_pairs", 64'(pairs_sent), 64'd0);
    @(posedge clk); #1;
    enable = 1'b0; smp_valid = 1'b0; rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_quiet", 64'({busy, avm_read | avm_write}), 64'd0);

    // Start-up sequence, then a 3-pair fill (min(3,5))
    fifospace = 32'h0305_0000;
    smp_valid = 1'b1;
    @(posedge clk); #1;
    enable = 1'b1;
    t0 = cyc;
    sb.push_back({2'd0, 32'h8});
    sb.push_back({2'd0, 32'h0});
    @(negedge clk); chk("c0_idle", 64'({busy, avm_write, avm_read}), 64'd0);
    @(negedge clk); chk("c1_clr", 64'({avm_write, avm_read, avm_address, busy}), 64'b1_0_00_1);
    @(negedge clk); chk("c2_clr_rel", 64'({avm_write, avm_read, avm_address, busy}), 64'b1_0_00_1);
    @(negedge clk); chk("c3_poll", 64'({avm_write, avm_read, avm_address, busy}), 64'b0_1_01_1);
    for (int i = 0; i < RD_LAT; i++) begin
      @(negedge clk); chk("wait_rd_no_ready", 64'(smp_ready), 64'd0);
    end
    @(negedge clk); chk("first_ready", 64'(smp_ready), 64'd1);
    for (int i = 0; i < 40 && hs_cyc.size() < 3; i++) @(negedge clk);
    chk("burst_hs_count", 64'(hs_cyc.size()), 64'd3);
    chk("first_hs_cycle", 64'(hs_cyc[0] - t0), 64'(4 + RD_LAT));
    chk("pair_rate_1", 64'(hs_cyc[1] - hs_cyc[0]), 64'd3);
    chk("pair_rate_2", 64'(hs_cyc[2] - hs_cyc[1]), 64'd3);
    @(posedge clk); #1;
    fifospace = 32'd0;
    for (int i = 0; i < 40 && rd_cyc.size() < 2; i++) @(negedge clk);
    chk("repoll_seen", 64'(rd_cyc.size()), 64'd2);
    chk("repoll_gap", 64'(rd_cyc[1] - last_wrr), 64'(POLL_GAP + 1));
    chk("space_obs_3", 64'(space_obs), 64'd3);
    chk("pairs_3", 64'(pairs_sent), 64'd3);

    // Empty FIFO: polling only, no ready
    base_rdy = ready_cnt;
    for (int i = 0; i < 80 && rd_cyc.size() < 5; i++) @(negedge clk);
    chk("empty_polls", 64'(rd_cyc.size()), 64'd5);
    for (int k = 2; k < 5; k++) begin
      chk("poll_period", 64'(rd_cyc[k] - rd_cyc[k-1]), 64'(POLL_PERIOD));
    end
    chk("empty_no_ready", 64'(ready_cnt - base_rdy), 64'd0);
    chk("empty_no_hs", 64'(hs_cyc.size()), 64'd3);
    chk("empty_space_obs", 64'(space_obs), 64'd0);

    // Starved source, then enable dropped right after the handshake
    @(posedge clk); #1;
    smp_valid = 1'b0;
    fifospace = 32'h0502_FFFF;
    for (int i = 0; i < 3 * POLL_PERIOD + 5 && !smp_ready; i++) @(negedge clk);
    chk("starve_ready", 64'(smp_ready), 64'd1);
    chk("space_obs_min", 64'(space_obs), 64'd2);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); chk("hold_ready_no_wr", 64'({smp_ready, avm_write}), 64'b10);
    end
    @(posedge clk); #1;
    smp_valid = 1'b1;
    @(posedge clk); #1;
    enable = 1'b0; smp_valid = 1'b0;
    @(negedge clk); chk("drop_wr_l", 64'({avm_write, avm_address}), 64'b1_10);
    @(negedge clk); chk("drop_wr_r", 64'({avm_write, avm_address}), 64'b1_11);
    @(negedge clk); chk("drop_idle", 64'({busy, smp_ready, avm_write, avm_read}), 64'd0);
    chk("pairs_4", 64'(pairs_sent), 64'd4);

    // Full 255-pair fill with re-enable (restarts with a FIFO clear)
    @(posedge clk); #1;
    fifospace = 32'hFFFF_0000;
    smp_valid = 1'b1;
    base_hs = hs_cyc.size();
    enable = 1'b1;
    sb.push_back({2'd0, 32'h8});
    sb.push_back({2'd0, 32'h0});
    for (int i = 0; i < 1200 && hs_cyc.size() < base_hs + 255; i++) @(negedge clk);
    chk("full_hs_count", 64'(hs_cyc.size() - base_hs), 64'd255);
    chk("space_obs_ff", 64'(space_obs), 64'hFF);
    @(posedge clk); #1;
    fifospace = 32'd0;
    repeat (20) @(negedge clk);
    chk("full_no_extra", 64'(hs_cyc.size() - base_hs), 64'd255);
    chk("pairs_259", 64'(pairs_sent), 64'd259);
    chk("full_space_obs_0", 64'(space_obs), 64'd0);

    // Async reset during a LEFTDATA write
    @(posedge clk); #1;
    fifospace = 32'h0101_0000;
    for (int i = 0; i < 40 && !(avm_write && avm_address == 2'd2); i++) @(negedge clk);
    chk("saw_wr_l", 64'({avm_write, avm_address}), 64'b1_10);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_quiet", 64'({avm_write, avm_read, avm_chipselect, busy, smp_ready}), 64'd0);
    chk("async_rst_pairs", 64'(pairs_sent), 64'd0);
    sb.delete();
    @(posedge clk); #1;
    @(posedge clk); #1;
    sb.push_back({2'd0, 32'h8});
    sb.push_back({2'd0, 32'h0});
    rst_n = 1'b1;
    for (int i = 0; i < 10 && !avm_write; i++) @(negedge clk);
    chk("restart_clr", 64'({avm_write, avm_address, avm_writedata}), 64'({1'b1, 2'd0, 32'h8}));

    // Wind down and drain the scoreboard
    @(posedge clk); #1;
    enable = 1'b0;
    repeat (20) @(negedge clk);
    chk("sb_drain", 64'(sb.size()), 64'd0);
    chk("final_idle", 64'(busy), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
